// File: rtl/nios_oci_dct_pkg.sv
// Shared constants, state encoding and symbol placement for the OCI DCT packer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package nios_oci_dct_pkg;

    localparam int SYM_W = 2;
    localparam int DEPTH = 15;
    localparam int CNT_W = 4;
    localparam int BUF_W = SYM_W * DEPTH;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_ENDED = 2'd2
    } state_e;

    // Symbol meanings as produced by the OCI trace logic; the packer does not interpret them.
    typedef enum logic [SYM_W-1:0] {
        DCT_NONE   = 2'd0,
        DCT_LOAD   = 2'd1,
        DCT_STORE  = 2'd2,
        DCT_MARKER = 2'd3
    } dct_sym_e;

    // OR a symbol into the buffer at slot idx (LSB-first packing).
    function automatic logic [BUF_W-1:0] place_sym(input logic [BUF_W-1:0] acc,
                                                   input logic [SYM_W-1:0] s,
                                                   input logic [CNT_W-1:0] idx);
        place_sym = acc | (BUF_W'(s) << (SYM_W * int'(idx)));
    endfunction

endpackage

// File: rtl/nios_base_inst_cpu_oci_dct_packer_if.sv
// Symbol input, packed-buffer output and end-of-test status bundle.
// Latency: n/a (wires only).
// Backpressure: sym_ready toward the producer, dct_ready from the consumer.
interface nios_base_inst_cpu_oci_dct_packer_if;
    import nios_oci_dct_pkg::*;

    logic             sym_valid;
    logic [SYM_W-1:0] sym;
    logic             sym_ready;
    logic             end_req;
    logic [BUF_W-1:0] dct_buffer;
    logic [CNT_W-1:0] dct_count;
    logic             dct_valid;
    logic             dct_ready;
    logic             test_ending;
    logic             test_has_ended;

    // Packer side.
    modport slave (
        input  sym_valid, sym, end_req, dct_ready,
        output sym_ready, dct_buffer, dct_count, dct_valid, test_ending, test_has_ended
    );

    // Producer/consumer side.
    modport master (
        output sym_valid, sym, end_req, dct_ready,
        input  sym_ready, dct_buffer, dct_count, dct_valid, test_ending, test_has_ended
    );

endinterface

// File: rtl/nios_oci_dct_out_slot.sv
// Single-entry holding register for a packed buffer and its symbol count.
// Latency: 1 cycle from load to out_vld.
// Backpressure: contents held while out_vld && !out_rdy; caller loads only when empty or draining.
module nios_oci_dct_out_slot
    import nios_oci_dct_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [BUF_W-1:0] load_buf,
    input  logic [CNT_W-1:0] load_cnt,
    input  logic             out_rdy,
    output logic             out_vld,
    output logic [BUF_W-1:0] out_buf,
    output logic [CNT_W-1:0] out_cnt
);

    logic             vld_q, vld_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Load wins over drain so back-to-back buffers leave no gap; a bare drain zeroes the slot.
    always_comb begin
        vld_d = vld_q;
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (load) begin
            vld_d = 1'b1;
            buf_d = load_buf;
            cnt_d = load_cnt;
        end else if (vld_q && out_rdy) begin
            vld_d = 1'b0;
            buf_d = '0;
            cnt_d = '0;
        end
    end

    // Slot registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= 1'b0;
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

    assign out_vld = vld_q;
    assign out_buf = buf_q;
    assign out_cnt = cnt_q;

endmodule

// File: rtl/nios_base_inst_cpu_oci_dct_packer.sv
// Packs 2-bit DCT symbols LSB-first into 15-symbol buffers and runs the end-of-test flush.
// Latency: full buffer visible 1 cycle after the 15th accept; flush loads 2 cycles after end_req.
// Backpressure: sym_ready drops only when the 15th symbol has no slot to go to; stalls in flush/ended.
module nios_base_inst_cpu_oci_dct_packer
    import nios_oci_dct_pkg::*;
(
    input  logic                                clk,
    input  logic                                reset,
    nios_base_inst_cpu_oci_dct_packer_if.slave  bus
);

    state_e           state_q, state_d;
    logic [BUF_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;

    logic             slot_load;
    logic [BUF_W-1:0] slot_buf;
    logic [CNT_W-1:0] slot_cnt;
    logic             slot_vld;
    logic [BUF_W-1:0] slot_out_buf;
    logic [CNT_W-1:0] slot_out_cnt;
    logic             slot_free;
    logic             acc_last;
    logic             sym_acc;

    assign slot_free = !slot_vld || bus.dct_ready;
    assign acc_last  = (acc_cnt_q == CNT_W'(DEPTH - 1));

    // Only the buffer-completing symbol needs the slot, so only it waits on dct_ready.
    assign bus.sym_ready = !reset && (state_q == S_RUN) &&
                           !(acc_last && slot_vld && !bus.dct_ready);
    assign sym_acc       = bus.sym_valid && bus.sym_ready;

    // Accumulate symbols, hand off full/partial buffers, and sequence run -> flush -> ended.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        acc_cnt_d = acc_cnt_q;
        slot_load = 1'b0;
        slot_buf  = acc_q;
        slot_cnt  = acc_cnt_q;
        case (state_q)
            S_RUN: begin
                if (sym_acc) begin
                    if (acc_last) begin
                        slot_load = 1'b1;
                        slot_buf  = place_sym(acc_q, bus.sym, acc_cnt_q);
                        slot_cnt  = CNT_W'(DEPTH);
                        acc_d     = '0;
                        acc_cnt_d = '0;
                    end else begin
                        acc_d     = place_sym(acc_q, bus.sym, acc_cnt_q);
                        acc_cnt_d = acc_cnt_q + 1'b1;
                    end
                end
                if (bus.end_req) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if ((acc_cnt_q != '0) && slot_free) begin
                    slot_load = 1'b1;
                    acc_d     = '0;
                    acc_cnt_d = '0;
                end
                if ((acc_cnt_q == '0) && !slot_vld) begin
                    state_d = S_ENDED;
                end
            end
            default: begin
            end
        endcase
    end

    // Packer state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_RUN;
            acc_q     <= '0;
            acc_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            acc_cnt_q <= acc_cnt_d;
        end
    end

    nios_oci_dct_out_slot u_slot (
        .clk      (clk),
        .reset    (reset),
        .load     (slot_load),
        .load_buf (slot_buf),
        .load_cnt (slot_cnt),
        .out_rdy  (bus.dct_ready),
        .out_vld  (slot_vld),
        .out_buf  (slot_out_buf),
        .out_cnt  (slot_out_cnt)
    );

    assign bus.dct_valid      = slot_vld;
    assign bus.dct_buffer     = slot_out_buf;
    assign bus.dct_count      = slot_out_cnt;
    assign bus.test_ending    = (state_q == S_FLUSH);
    assign bus.test_has_ended = (state_q == S_ENDED);

endmodule

// File: tb/tb_nios_base_inst_cpu_oci_dct_packer.sv
// Self-checking bench for the OCI DCT packer: vector table, directed corner sequences, random traffic.
// Latency: n/a.
// Backpressure: bench drives dct_ready directly.
module tb_nios_base_inst_cpu_oci_dct_packer;
    import nios_oci_dct_pkg::*;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    nios_base_inst_cpu_oci_dct_packer_if bus();

    nios_base_inst_cpu_oci_dct_packer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: accumulator as a queue of symbols, slot as plain fields, phase 0/1/2.
    int          m_acc[$];
    logic        m_sv;
    logic [3:0]  m_sc;
    logic [29:0] m_sb;
    int          m_ph;
    logic        last_rdy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [29:0] pack_q();
        logic [29:0] b = '0;
        for (int i = 0; i < m_acc.size(); i++) b = b | (30'(m_acc[i]) << (2 * i));
        return b;
    endfunction

    function automatic logic m_ready(input logic r);
        return (m_ph == 0) && !(m_acc.size() == DEPTH - 1 && m_sv && !r);
    endfunction

    function automatic void model_reset();
        m_acc.delete();
        m_sv = 1'b0; m_sc = '0; m_sb = '0; m_ph = 0;
    endfunction

    function automatic void model_step(input logic v, input logic [1:0] s,
                                       input logic r, input logic e);
        logic take  = v && m_ready(r);
        logic old_v = m_sv;
        int   old_n = m_acc.size();
        logic free  = !old_v || r;
        if (old_v && r) begin
            m_sv = 1'b0; m_sc = '0; m_sb = '0;
        end
        if (m_ph == 0) begin
            if (take) begin
                m_acc.push_back(int'(s));
                if (m_acc.size() == DEPTH) begin
                    m_sv = 1'b1; m_sc = 4'(DEPTH); m_sb = pack_q();
                    m_acc.delete();
                end
            end
            if (e) m_ph = 1;
        end else if (m_ph == 1) begin
            if (old_n > 0 && free) begin
                m_sv = 1'b1; m_sc = 4'(old_n); m_sb = pack_q();
                m_acc.delete();
            end
            if (old_n == 0 && !old_v) m_ph = 2;
        end
    endfunction

    // One clock: drive at negedge, check sym_ready before the edge, check registered outputs after.
    task automatic cyc(input logic v, input logic [1:0] s, input logic r, input logic e);
        bus.sym_valid = v; bus.sym = s; bus.dct_ready = r; bus.end_req = e;
        #1;
        last_rdy = bus.sym_ready;
        check("sym_ready", 32'(bus.sym_ready), 32'(m_ready(r)));
        model_step(v, s, r, e);
        @(negedge clk);
        check("dct_valid", 32'(bus.dct_valid), 32'(m_sv));
        check("dct_count", 32'(bus.dct_count), 32'(m_sc));
        check("dct_buffer", 32'(bus.dct_buffer), 32'(m_sb));
        check("test_ending", 32'(bus.test_ending), 32'(m_ph == 1));
        check("test_has_ended", 32'(bus.test_has_ended), 32'(m_ph == 2));
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.sym_valid = 1'b0; bus.sym = '0; bus.dct_ready = 1'b0; bus.end_req = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_dct_valid", 32'(bus.dct_valid), 32'd0);
        check("rst_dct_count", 32'(bus.dct_count), 32'd0);
        check("rst_dct_buffer", 32'(bus.dct_buffer), 32'd0);
        check("rst_test_ending", 32'(bus.test_ending), 32'd0);
        check("rst_test_has_ended", 32'(bus.test_has_ended), 32'd0);
        check("rst_sym_ready", 32'(bus.sym_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic        v;
        logic [1:0]  s;
        logic        r;
        logic        e;
        logic        x_rdy;
        logic        x_vld;
        logic [3:0]  x_cnt;
        logic [29:0] x_buf;
    } vec_t;

    vec_t vt[18];

    initial begin
        int nbuf;
        logic low_seen;
        reset = 1'b0;
        bus.sym_valid = 1'b0; bus.sym = '0; bus.dct_ready = 1'b0; bus.end_req = 1'b0;
        model_reset();

        // 0,1,2,3 repeating: 15th accept yields symbols 0..14 packed = 30'h24E4E4E4.
        for (int i = 0; i < 15; i++) begin
            vt[i] = '{1'b1, 2'(i % 4), 1'b1, 1'b0, 1'b1, (i == 14),
                      (i == 14) ? 4'd15 : 4'd0, (i == 14) ? 30'h24E4E4E4 : 30'h0};
        end
        vt[15] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 30'h0};
        vt[16] = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 30'h0};
        vt[17] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 30'h3};

        do_reset();
        foreach (vt[i]) begin
            cyc(vt[i].v, vt[i].s, vt[i].r, vt[i].e);
            check("vec_sym_ready", 32'(last_rdy), 32'(vt[i].x_rdy));
            check("vec_dct_valid", 32'(bus.dct_valid), 32'(vt[i].x_vld));
            check("vec_dct_count", 32'(bus.dct_count), 32'(vt[i].x_cnt));
            check("vec_dct_buffer", 32'(bus.dct_buffer), 32'(vt[i].x_buf));
        end

        // 32 back-to-back symbols: two full buffers, ready never drops, 2 left for the flush.
        do_reset();
        nbuf = 0; low_seen = 1'b0;
        for (int i = 0; i < 32; i++) begin
            cyc(1'b1, 2'($urandom_range(0, 3)), 1'b1, 1'b0);
            if (!last_rdy) low_seen = 1'b1;
            if (bus.dct_valid) nbuf++;
        end
        check("b2b_ready_low", 32'(low_seen), 32'd0);
        check("b2b_buffers", 32'(nbuf), 32'd2);
        cyc(1'b0, 2'd0, 1'b1, 1'b1);
        cyc(1'b0, 2'd0, 1'b1, 1'b0);
        check("b2b_left", 32'(bus.dct_count), 32'd2);

        // Full slot stalls the 15th symbol; releasing dct_ready accepts it with no gap.
        do_reset();
        for (int i = 0; i < 29; i++) cyc(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
        cyc(1'b1, 2'd2, 1'b0, 1'b0);
        check("stall_ready_low", 32'(last_rdy), 32'd0);
        cyc(1'b1, 2'd3, 1'b1, 1'b0);
        check("stall_accept", 32'(last_rdy), 32'd1);
        check("stall_reload_vld", 32'(bus.dct_valid), 32'd1);
        check("stall_reload_cnt", 32'(bus.dct_count), 32'd15);

        // Five 3s then end_req: partial buffer 30'h3FF, ended two cycles after the drain.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 2'd3, 1'b0, 1'b0);
        cyc(1'b0, 2'd0, 1'b0, 1'b1);
        check("flush_ending", 32'(bus.test_ending), 32'd1);
        check("flush_not_loaded", 32'(bus.dct_valid), 32'd0);
        cyc(1'b0, 2'd0, 1'b0, 1'b0);
        check("flush_cnt", 32'(bus.dct_count), 32'd5);
        check("flush_buf", 32'(bus.dct_buffer), 32'h3FF);
        cyc(1'b0, 2'd0, 1'b1, 1'b0);
        check("flush_m1_ended", 32'(bus.test_has_ended), 32'd0);
        cyc(1'b0, 2'd0, 1'b0, 1'b0);
        check("flush_m2_ended", 32'(bus.test_has_ended), 32'd1);

        // end_req straight after reset: no buffer, ended at N+2, later end_req ignored.
        do_reset();
        cyc(1'b0, 2'd0, 1'b0, 1'b1);
        check("empty_ending", 32'(bus.test_ending), 32'd1);
        cyc(1'b0, 2'd0, 1'b0, 1'b0);
        check("empty_ended", 32'(bus.test_has_ended), 32'd1);
        check("empty_no_buf", 32'(bus.dct_valid), 32'd0);
        cyc(1'b1, 2'd1, 1'b1, 1'b1);
        check("ended_sticky", 32'(bus.test_has_ended), 32'd1);
        check("ended_no_ready", 32'(last_rdy), 32'd0);

        // Reset with slot full and 7 symbols pending discards everything.
        do_reset();
        for (int i = 0; i < 22; i++) cyc(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
        check("pre_rst_full", 32'(bus.dct_valid), 32'd1);
        do_reset();
        cyc(1'b0, 2'd0, 1'b1, 1'b0);
        check("post_rst_ready", 32'(last_rdy), 32'd1);
        check("post_rst_run", 32'(bus.test_ending), 32'd0);

        // Random traffic against the model; restart after each completed end sequence.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
                ($urandom_range(0, 9) < 6), ($urandom_range(0, 299) == 0));
            if (m_ph == 2 && $urandom_range(0, 3) == 0) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
